// File: rtl/npc_pkg.sv
// Shared encodings and default addresses for the next-PC unit.
package npc_pkg;
  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_REG    = 2'd3
  } npc_sel_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
endpackage

// File: rtl/npc_ras.sv
// Circular return-address stack; when full, a push silently drops the oldest entry.
module npc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             top,
  output logic                         valid,
  output logic [$clog2(RAS_DEPTH):0]   count
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    sp;
  logic [PW-1:0]    sp_m1;
  logic [CW-1:0]    cnt;
  logic             full, empty;

  assign sp_m1 = sp - 1'b1;
  assign full  = (cnt == CW'(RAS_DEPTH));
  assign empty = (cnt == '0);

  // sp points at the next free slot; when full that slot is also the oldest entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp  <= '0;
      cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
    end else if (push && pop && !empty) begin
      mem[sp_m1] <= push_data;
    end else if (push) begin
      mem[sp] <= push_data;
      sp      <= sp + 1'b1;
      if (!full) cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      sp  <= sp_m1;
      cnt <= cnt - 1'b1;
    end
  end

  assign top   = empty ? '0 : mem[sp_m1];
  assign valid = !empty;
  assign count = cnt;
endmodule

// File: rtl/npc_unit.sv
// Fetch PC register with exception/eret/stall priority and a return-address stack.
module npc_unit
  import npc_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
  parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(EXC_VEC_DEF),
  parameter int              RAS_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic [1:0]                  npc_sel,
  input  logic [WIDTH-1:0]            pc4_D,
  input  logic [25:0]                 imm26,
  input  logic [WIDTH-1:0]            reg_target,
  input  logic                        exc,
  input  logic                        eret,
  input  logic [WIDTH-1:0]            epc,
  input  logic                        ras_push,
  input  logic                        ras_pop,
  output logic [WIDTH-1:0]            pc,
  output logic [WIDTH-1:0]            pc4,
  output logic [WIDTH-1:0]            ras_top,
  output logic                        ras_valid,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        misalign
);
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] br_off;
  logic             ras_en;

  assign br_off = {{(WIDTH-18){imm26[15]}}, imm26[15:0], 2'b00};
  assign pc4    = pc + WIDTH'(4);

  always_comb begin
    pc_nxt = pc;
    if (exc)        pc_nxt = EXC_VEC;
    else if (eret)  pc_nxt = epc;
    else if (!stall) begin
      unique case (npc_sel_e'(npc_sel))
        NPC_SEQ:    pc_nxt = pc4;
        NPC_BRANCH: pc_nxt = pc4_D + br_off;
        NPC_JUMP:   pc_nxt = {pc4_D[WIDTH-1:28], imm26, 2'b00};
        NPC_REG:    pc_nxt = reg_target;
        default:    pc_nxt = pc4;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_nxt;
  end

  assign misalign = |pc[1:0];

  // Any redirect or stall freezes the stack for this cycle
  assign ras_en = !stall && !exc && !eret;

  npc_ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push && ras_en),
    .pop       (ras_pop && ras_en),
    .push_data (pc4_D + WIDTH'(4)),
    .top       (ras_top),
    .valid     (ras_valid),
    .count     (ras_count)
  );
endmodule

// File: tb/tb_npc_unit.sv
// Self-checking bench for npc_unit: directed table, RAS sequences, random vs. reference model.
module tb_npc_unit;
  localparam int DEPTH = 4;

  logic        clk = 0, reset = 1, stall = 0, exc = 0, eret = 0, ras_push = 0, ras_pop = 0;
  logic [1:0]  npc_sel = 0;
  logic [31:0] pc4_D = 0, reg_target = 0, epc = 0;
  logic [25:0] imm26 = 0;
  logic [31:0] pc, pc4, ras_top;
  logic        ras_valid, misalign;
  logic [2:0]  ras_count;

  int tests = 0, fails = 0;

  // reference model state
  logic [31:0] mpc;
  logic [31:0] mq[$];

  npc_unit #(.WIDTH(32), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel), .pc4_D(pc4_D),
    .imm26(imm26), .reg_target(reg_target), .exc(exc), .eret(eret), .epc(epc),
    .ras_push(ras_push), .ras_pop(ras_pop), .pc(pc), .pc4(pc4), .ras_top(ras_top),
    .ras_valid(ras_valid), .ras_count(ras_count), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] pc4d;
    logic [25:0] imm;
    logic [31:0] rt;
    logic        st, ex, er;
    logic [31:0] ep;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] nxt, pd;
    int off;
    nxt = mpc;
    off = int'($signed(imm26[15:0]));
    if (exc) nxt = 32'h4180;
    else if (eret) nxt = epc;
    else if (!stall) begin
      case (npc_sel)
        2'd0: nxt = mpc + 4;
        2'd1: nxt = pc4_D + 32'(off * 4);
        2'd2: nxt = (pc4_D & 32'hF000_0000) | (32'(imm26) * 4);
        default: nxt = reg_target;
      endcase
    end
    if (!stall && !exc && !eret) begin
      pd = pc4_D + 4;
      if (ras_push && ras_pop && mq.size() > 0) mq[mq.size()-1] = pd;
      else if (ras_push) begin
        mq.push_back(pd);
        if (mq.size() > DEPTH) void'(mq.pop_front());
      end else if (ras_pop && mq.size() > 0) void'(mq.pop_back());
    end
    mpc = nxt;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] pd, input logic [25:0] im,
                       input logic [31:0] rt, input logic st, input logic ex, input logic er,
                       input logic [31:0] ep, input logic pu, input logic po);
    npc_sel = sel; pc4_D = pd; imm26 = im; reg_target = rt; stall = st; exc = ex;
    eret = er; epc = ep; ras_push = pu; ras_pop = po;
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; mpc = 32'h3000; mq.delete();
    #12; @(negedge clk); reset = 0;
  endtask

  task automatic chk_model(input string tag);
    logic [31:0] et;
    et = (mq.size() > 0) ? mq[mq.size()-1] : 32'h0;
    chk({tag, ".pc"}, pc, mpc);
    chk({tag, ".pc4"}, pc4, mpc + 4);
    chk({tag, ".mis"}, 32'(misalign), 32'(mpc[1:0] != 0));
    chk({tag, ".cnt"}, 32'(ras_count), mq.size());
    chk({tag, ".top"}, ras_top, et);
    chk({tag, ".vld"}, 32'(ras_valid), 32'(mq.size() > 0));
  endtask

  initial begin
    tbl.push_back('{2'd0, 32'h0, 26'h0, 32'h0, 0, 0, 0, 32'h0, 32'h3004, 0});
    tbl.push_back('{2'd0, 32'h0, 26'h0, 32'h0, 0, 0, 0, 32'h0, 32'h3008, 0});
    tbl.push_back('{2'd0, 32'h0, 26'h0, 32'h0, 0, 0, 0, 32'h0, 32'h300C, 0});
    tbl.push_back('{2'd1, 32'h3010, 26'h000FFFC, 32'h0, 0, 0, 0, 32'h0, 32'h3000, 0});
    tbl.push_back('{2'd2, 32'h3010, 26'h0000C10, 32'h0, 0, 0, 0, 32'h0, 32'h3040, 0});
    tbl.push_back('{2'd1, 32'h5000, 26'h0000010, 32'h0, 1, 0, 0, 32'h0, 32'h3040, 0});
    tbl.push_back('{2'd1, 32'h5000, 26'h0000010, 32'h0, 1, 0, 0, 32'h0, 32'h3040, 0});
    tbl.push_back('{2'd1, 32'h5000, 26'h0000010, 32'h0, 1, 1, 0, 32'h0, 32'h4180, 0});
    tbl.push_back('{2'd2, 32'h5000, 26'h0000010, 32'h0, 1, 0, 1, 32'h3024, 32'h3024, 0});
    tbl.push_back('{2'd3, 32'h0, 26'h0, 32'h3002, 0, 0, 0, 32'h0, 32'h3002, 1});
    tbl.push_back('{2'd0, 32'h0, 26'h0, 32'h0, 0, 0, 0, 32'h0, 32'h3006, 1});
    tbl.push_back('{2'd3, 32'h0, 26'h0, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 0});
    tbl.push_back('{2'd0, 32'h0, 26'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0000_0000, 0});
    tbl.push_back('{2'd1, 32'h10, 26'h0008000, 32'h0, 0, 0, 0, 32'h0, 32'hFFFE_0010, 0});
    tbl.push_back('{2'd2, 32'hA000_0000, 26'h3FFFFFF, 32'h0, 0, 0, 0, 32'h0, 32'hAFFF_FFFC, 0});
    tbl.push_back('{2'd3, 32'h0, 26'h0, 32'h1234, 0, 1, 1, 32'h7777, 32'h4180, 0});

    do_reset();
    chk("rst.pc", pc, 32'h3000);
    chk("rst.pc4", pc4, 32'h3004);
    chk("rst.cnt", 32'(ras_count), 0);
    chk("rst.vld", 32'(ras_valid), 0);
    chk("rst.top", ras_top, 0);
    chk("rst.mis", 32'(misalign), 0);

    foreach (tbl[i]) begin
      drive(tbl[i].sel, tbl[i].pc4d, tbl[i].imm, tbl[i].rt, tbl[i].st, tbl[i].ex,
            tbl[i].er, tbl[i].ep, 0, 0);
      chk($sformatf("vec%0d.pc", i), pc, tbl[i].exp_pc);
      chk($sformatf("vec%0d.mis", i), 32'(misalign), 32'(tbl[i].exp_mis));
    end

    // RAS overflow and drain
    do_reset();
    for (int i = 0; i < 5; i++) drive(0, 32'h3000 + 32'(i) * 32'h100, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("ras.full.cnt", 32'(ras_count), 4);
    chk("ras.full.top", ras_top, 32'h3404);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    chk("ras.stallpop.cnt", 32'(ras_count), 4);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ras.pop1.top", ras_top, 32'h3304);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ras.pop2.top", ras_top, 32'h3204);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ras.pop3.top", ras_top, 32'h3104);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ras.pop4.vld", 32'(ras_valid), 0);
    chk("ras.pop4.top", ras_top, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ras.pop5.cnt", 32'(ras_count), 0);

    // simultaneous push+pop replaces top
    drive(0, 32'h3000, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 32'h3100, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 32'h3500, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("ras.pp.cnt", 32'(ras_count), 2);
    chk("ras.pp.top", ras_top, 32'h3504);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ras.pp.below", ras_top, 32'h3004);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 32'h3600, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("ras.ppempty.cnt", 32'(ras_count), 1);
    chk("ras.ppempty.top", ras_top, 32'h3604);

    // randomized run against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rt;
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      drive(2'($urandom_range(0, 3)), $urandom, 26'($urandom), rt,
            $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0);
      chk_model($sformatf("rnd%0d", i));
    end

    // asynchronous reset mid-cycle while a push and jump are pending
    drive(0, 32'h3000, 0, 0, 0, 0, 0, 0, 1, 0);
    npc_sel = 2'd2; pc4_D = 32'h8000_0000; imm26 = 26'h0123456; ras_push = 1;
    stall = 0; exc = 0; eret = 0;
    #2 reset = 1;
    #1;
    chk("arst.pc", pc, 32'h3000);
    chk("arst.cnt", 32'(ras_count), 0);
    chk("arst.top", ras_top, 0);
    @(negedge clk); reset = 0;
    mpc = 32'h3000; mq.delete();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_model("post_arst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
